vga_pattern_gen: RTL and testbench

- Parametrised, pipelined pixel-colour generator. Sits between the VGA timing block (x, y, video_on, frame_start) and the DAC/pin outputs.
- Generalises the plain colour pass-through to configurable per-channel colour depth and four selectable display modes: solid, scrolling colour bars, checkerboard, gradient.
- Mode changes apply only at frame boundaries, so the picture never tears.

---
 rtl/vga_pattern_gen_if.sv | 25 ++
 rtl/vga_pattern_gen.sv | 122 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the VGA timing source and vga_pattern_gen: timing, mode control,
// user colour in; registered pixel colour and its valid flag out.
interface vga_pattern_gen_if #(
  parameter int unsigned CW = 4
) ();
  logic              video_on;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              frame_start;
  logic [1:0]        mode_in;
  logic              mode_we;
  logic [3*CW-1:0]   img;
  logic [3*CW-1:0]   rgb;
  logic              rgb_valid;

  modport master (
    output video_on, x, y, frame_start, mode_in, mode_we, img,
    input  rgb, rgb_valid
  );

  modport slave (
    input  video_on, x, y, frame_start, mode_in, mode_we, img,
    output rgb, rgb_valid
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel colour generator: solid, scrolling bars, checkerboard, gradient.
// Define VGA_PATTERN_BORDER_EN to force a white one-pixel frame around the active area.
module vga_pattern_gen #(
  parameter int unsigned CW        = 4,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned TILE_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_pattern_gen_if.slave  bus
);

  localparam int unsigned RGB_W = 3 * CW;
  localparam int unsigned XW    = 10;
  localparam int unsigned SW    = XW + 1;
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  mode_e             mode_pend_q, mode_pend_d;
  mode_e             mode_act_q,  mode_act_d;
  logic [XW-1:0]     scroll_q,    scroll_d;

  logic [XW-1:0]     x_s1_q, y_s1_q, scroll_s1_q;
  logic              von_s1_q;
  logic [RGB_W-1:0]  img_s1_q;
  mode_e             mode_s1_q;

  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              von_s2_q;

  // Mode latch and scroll counter; both only move on frame_start / mode_we
  always_comb begin
    mode_pend_d = mode_pend_q;
    mode_act_d  = mode_act_q;
    scroll_d    = scroll_q;
    if (bus.mode_we) begin
      mode_pend_d = mode_e'(bus.mode_in);
    end
    if (bus.frame_start) begin
      mode_act_d = bus.mode_we ? mode_e'(bus.mode_in) : mode_pend_q;
      scroll_d   = (scroll_q == XW'(H_ACTIVE - 1)) ? '0 : scroll_q + XW'(1);
    end
  end

  logic [SW-1:0]     xs_sum, xs;
  logic [2:0]        bar;
  logic [RGB_W-1:0]  bar_rgb, pix;
  logic              blank, tile_odd;
`ifdef VGA_PATTERN_BORDER_EN
  logic              on_edge;
`endif

  // Stage-2 colour select from the stage-1 snapshot
  always_comb begin
    xs_sum   = {1'b0, x_s1_q} + {1'b0, scroll_s1_q};
    xs       = (xs_sum >= SW'(H_ACTIVE)) ? xs_sum - SW'(H_ACTIVE) : xs_sum;
    bar      = 3'(xs / SW'(BAR_W));
    // Bar order white..black makes each channel the inverse of one bar-index bit
    bar_rgb  = {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
    tile_odd = x_s1_q[TILE_LOG2] ^ y_s1_q[TILE_LOG2];
    blank    = !von_s1_q || ({1'b0, x_s1_q} >= SW'(H_ACTIVE)) ||
               ({1'b0, y_s1_q} >= SW'(V_ACTIVE));

    pix = img_s1_q;
    case (mode_s1_q)
      MODE_SOLID:    pix = img_s1_q;
      MODE_BARS:     pix = bar_rgb;
      MODE_CHECKER:  pix = tile_odd ? ~img_s1_q : img_s1_q;
      MODE_GRADIENT: pix = {x_s1_q[XW-1 -: CW], y_s1_q[XW-1 -: CW], scroll_s1_q[XW-1 -: CW]};
      default:       pix = img_s1_q;
    endcase

`ifdef VGA_PATTERN_BORDER_EN
    on_edge = (x_s1_q == XW'(0)) || (x_s1_q == XW'(H_ACTIVE - 1)) ||
              (y_s1_q == XW'(0)) || (y_s1_q == XW'(V_ACTIVE - 1));
    if (blank)        rgb_d = '0;
    else if (on_edge) rgb_d = '1;
    else              rgb_d = pix;
`else
    rgb_d = blank ? '0 : pix;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_pend_q <= MODE_SOLID;
      mode_act_q  <= MODE_SOLID;
      scroll_q    <= '0;
      x_s1_q      <= '0;
      y_s1_q      <= '0;
      scroll_s1_q <= '0;
      von_s1_q    <= 1'b0;
      img_s1_q    <= '0;
      mode_s1_q   <= MODE_SOLID;
      rgb_q       <= '0;
      von_s2_q    <= 1'b0;
    end else begin
      mode_pend_q <= mode_pend_d;
      mode_act_q  <= mode_act_d;
      scroll_q    <= scroll_d;
      x_s1_q      <= bus.x;
      y_s1_q      <= bus.y;
      scroll_s1_q <= scroll_q;
      von_s1_q    <= bus.video_on;
      img_s1_q    <= bus.img;
      mode_s1_q   <= mode_act_q;
      rgb_q       <= rgb_d;
      von_s2_q    <= von_s1_q;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.rgb_valid = von_s2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed scenarios plus randomized traffic checked
// against an arithmetic pixel model with a two-cycle expectation pipe.
module tb_vga_pattern_gen;

  localparam int unsigned CW = 4;
  localparam int H = 640;
  localparam int V = 480;
  localparam int T = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.CW(CW)) bus ();

  vga_pattern_gen #(
    .CW(CW), .H_ACTIVE(H), .V_ACTIVE(V), .TILE_LOG2(T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int          m_pend, m_act, m_scroll;
  logic [11:0] s1_exp, exp_rgb;
  logic        s1_von, exp_valid;
  logic [11:0] bar_tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Expected colour of one pixel straight from the mode definitions
  function automatic logic [11:0] model_pixel(int m, int sc, int xx, int yy,
                                              logic von, logic [11:0] im);
    int xs, r, g, b;
    if (!von || xx >= H || yy >= V) return 12'h000;
`ifdef VGA_PATTERN_BORDER_EN
    if (xx == 0 || xx == H - 1 || yy == 0 || yy == V - 1) return 12'hFFF;
`endif
    case (m)
      0: return im;
      1: begin
        xs = (xx + sc) % H;
        return bar_tbl[xs / (H / 8)];
      end
      2: return (((xx / (1 << T)) + (yy / (1 << T))) % 2 == 1) ? ~im : im;
      default: begin
        r = xx * 16 / 1024;
        g = yy * 16 / 1024;
        b = sc * 16 / 1024;
        return {4'(r), 4'(g), 4'(b)};
      end
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_act = 0; m_scroll = 0;
    s1_exp = '0; s1_von = 1'b0; exp_rgb = '0; exp_valid = 1'b0;
  endtask

  // One clock: model consumes the inputs seen at this edge; exp_* then describe the outputs
  task automatic tick();
    logic [11:0] p;
    int old_pend;
    @(posedge clk);
    p = model_pixel(m_act, m_scroll, int'(bus.x), int'(bus.y), bus.video_on, bus.img);
    exp_rgb   = s1_exp;
    exp_valid = s1_von;
    s1_exp    = p;
    s1_von    = bus.video_on;
    old_pend  = m_pend;
    if (bus.mode_we) m_pend = int'(bus.mode_in);
    if (bus.frame_start) begin
      m_act    = bus.mode_we ? int'(bus.mode_in) : old_pend;
      m_scroll = (m_scroll + 1) % H;
    end
    #1;
  endtask

  task automatic frame(input logic we, input logic [1:0] m);
    bus.video_on = 1'b0; bus.frame_start = 1'b1; bus.mode_we = we; bus.mode_in = m;
    tick();
    bus.frame_start = 1'b0; bus.mode_we = 1'b0;
  endtask

  task automatic show_px(input int xx, input int yy);
    bus.x = 10'(xx); bus.y = 10'(yy); bus.video_on = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected %h", bus.rgb, 12'h000); end
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rgb_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_latency_blanking();
    bus.img = 12'hA5C; bus.x = 10'd100; bus.y = 10'd100; bus.video_on = 1'b0;
    repeat (3) tick();
    bus.video_on = 1'b1;
    tick();
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL latency_early_valid: got %b expected 0", bus.rgb_valid); end
    tick();
    checks++; if (bus.rgb !== 12'hA5C) begin errors++; $display("FAIL latency_rgb: got %h expected %h", bus.rgb, 12'hA5C); end
    checks++; if (bus.rgb_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", bus.rgb_valid); end
    show_px(640, 100);
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL blank_x640: got %h expected %h", bus.rgb, 12'h000); end
    checks++; if (bus.rgb_valid !== 1'b1) begin errors++; $display("FAIL blank_x640_valid: got %b expected 1", bus.rgb_valid); end
    show_px(100, 480);
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL blank_y480: got %h expected %h", bus.rgb, 12'h000); end
  endtask

  task automatic test_mode_timing();
    bus.img = 12'hA5C; bus.x = 10'd80; bus.y = 10'd100; bus.video_on = 1'b1;
    bus.mode_we = 1'b1; bus.mode_in = 2'd1;
    tick();
    bus.mode_we = 1'b0;
    tick(); tick();
    checks++; if (bus.rgb !== 12'hA5C) begin errors++; $display("FAIL mode_midframe_hold: got %h expected %h", bus.rgb, 12'hA5C); end
    frame(1'b0, 2'd0);
    show_px(80, 100);
    checks++; if (bus.rgb !== 12'hFF0) begin errors++; $display("FAIL mode_after_frame: got %h expected %h", bus.rgb, 12'hFF0); end
    frame(1'b1, 2'd0);
    show_px(80, 100);
    checks++; if (bus.rgb !== 12'hA5C) begin errors++; $display("FAIL mode_bypass_solid: got %h expected %h", bus.rgb, 12'hA5C); end
    frame(1'b1, 2'd1);
    show_px(80, 100);
    checks++; if (bus.rgb !== 12'hFF0) begin errors++; $display("FAIL mode_bypass_bars: got %h expected %h", bus.rgb, 12'hFF0); end
  endtask

  task automatic test_colour_bars();
    int          xl [3] = '{0, 80, 639};
    logic [11:0] el [3];
    logic [11:0] e0;
`ifdef VGA_PATTERN_BORDER_EN
    el = '{12'hFFF, 12'hFF0, 12'hFFF};
    e0 = 12'hFFF;
`else
    el = '{12'hFFF, 12'hFF0, 12'h000};
    e0 = 12'hFF0;
`endif
    while (m_scroll != 0) frame(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      show_px(xl[i], 100);
      checks++; if (bus.rgb !== el[i]) begin errors++; $display("FAIL bars_x%0d: got %h expected %h", xl[i], bus.rgb, el[i]); end
    end
    repeat (80) frame(1'b0, 2'd0);
    show_px(0, 100);
    checks++; if (bus.rgb !== e0) begin errors++; $display("FAIL bars_scroll80_x0: got %h expected %h", bus.rgb, e0); end
    show_px(1, 100);
    checks++; if (bus.rgb !== 12'hFF0) begin errors++; $display("FAIL bars_scroll80_x1: got %h expected %h", bus.rgb, 12'hFF0); end
    repeat (560) frame(1'b0, 2'd0);
    show_px(1, 100);
    checks++; if (bus.rgb !== 12'hFFF) begin errors++; $display("FAIL bars_wrap_x1: got %h expected %h", bus.rgb, 12'hFFF); end
    show_px(80, 100);
    checks++; if (bus.rgb !== 12'hFF0) begin errors++; $display("FAIL bars_wrap_x80: got %h expected %h", bus.rgb, 12'hFF0); end
  endtask

  task automatic test_checkerboard();
    int          xl [3] = '{0, 32, 32};
    int          yl [3] = '{0, 0, 32};
    logic [11:0] el [3];
`ifdef VGA_PATTERN_BORDER_EN
    el = '{12'hFFF, 12'hFFF, 12'h123};
`else
    el = '{12'h123, 12'hEDC, 12'h123};
`endif
    frame(1'b1, 2'd2);
    bus.img = 12'h123;
    for (int i = 0; i < 3; i++) begin
      show_px(xl[i], yl[i]);
      checks++; if (bus.rgb !== el[i]) begin errors++; $display("FAIL checker_%0d_%0d: got %h expected %h", xl[i], yl[i], bus.rgb, el[i]); end
    end
    show_px(40, 70);
    checks++; if (bus.rgb !== 12'hEDC) begin errors++; $display("FAIL checker_40_70: got %h expected %h", bus.rgb, 12'hEDC); end
  endtask

  task automatic test_gradient();
    logic [11:0] e;
`ifdef VGA_PATTERN_BORDER_EN
    e = 12'hFFF;
`else
    e = 12'h970;
`endif
    frame(1'b1, 2'd3);
    while (m_scroll != 0) frame(1'b0, 2'd0);
    show_px(639, 479);
    checks++; if (bus.rgb !== e) begin errors++; $display("FAIL gradient_corner: got %h expected %h", bus.rgb, e); end
    show_px(320, 240);
    checks++; if (bus.rgb !== 12'h530) begin errors++; $display("FAIL gradient_mid: got %h expected %h", bus.rgb, 12'h530); end
  endtask

  task automatic test_random();
    int xe [4] = '{0, 1, 639, 640};
    int ye [4] = '{0, 31, 479, 480};
    for (int i = 0; i < 3000; i++) begin
      bus.video_on    = ($urandom % 4) != 0;
      bus.x           = ($urandom % 8 == 0) ? 10'(xe[$urandom % 4]) : 10'($urandom_range(0, 700));
      bus.y           = ($urandom % 8 == 0) ? 10'(ye[$urandom % 4]) : 10'($urandom_range(0, 520));
      bus.img         = 12'($urandom);
      bus.mode_in     = 2'($urandom);
      bus.mode_we     = ($urandom % 40) == 0;
      bus.frame_start = ($urandom % 60) == 0;
      tick();
      checks++; if (bus.rgb !== exp_rgb) begin errors++; $display("FAIL random_rgb[%0d]: got %h expected %h", i, bus.rgb, exp_rgb); end
      checks++; if (bus.rgb_valid !== exp_valid) begin errors++; $display("FAIL random_valid[%0d]: got %b expected %b", i, bus.rgb_valid, exp_valid); end
    end
    bus.mode_we = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] im;
    frame(1'b1, 2'd1);
    bus.img = 12'h456;
    show_px(200, 200);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb: got %h expected %h", bus.rgb, 12'h000); end
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.rgb_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    im = 12'($urandom);
    bus.img = im;
    show_px(10, 10);
    checks++; if (bus.rgb !== im) begin errors++; $display("FAIL postreset_solid: got %h expected %h", bus.rgb, im); end
    checks++; if (bus.rgb_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid: got %b expected 1", bus.rgb_valid); end
    frame(1'b1, 2'd1);
    show_px(79, 10);
    checks++; if (bus.rgb !== 12'hFF0) begin errors++; $display("FAIL postreset_scroll: got %h expected %h", bus.rgb, 12'hFF0); end
  endtask

  initial begin
    bus.video_on = 1'b0; bus.x = '0; bus.y = '0; bus.frame_start = 1'b0;
    bus.mode_in = '0; bus.mode_we = 1'b0; bus.img = '0;
    model_reset();
    test_reset();
    test_latency_blanking();
    test_mode_timing();
    test_colour_bars();
    test_checkerboard();
    test_gradient();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
